alu_4bit: RTL and testbench



---
 rtl/alu_4bit_if.sv | 20 ++
 rtl/alu_4bit.sv | 69 ++++++
 tb/tb_alu_4bit.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_4bit_if.sv
// Operand/select/result bundle for the 4-bit ALU slice.
// Port z is carried only when ALU_ZERO_FLAG_EN is defined.
interface alu_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       s0, s1, s2, s3;
  logic       c0;
  logic       il, ir;
  logic [3:0] f;
  logic       c8;
`ifdef ALU_ZERO_FLAG_EN
  logic       z;

  modport master (output a, b, s0, s1, s2, s3, c0, il, ir, input  f, c8, z);
  modport slave  (input  a, b, s0, s1, s2, s3, c0, il, ir, output f, c8, z);
`else
  modport master (output a, b, s0, s1, s2, s3, c0, il, ir, input  f, c8);
  modport slave  (input  a, b, s0, s1, s2, s3, c0, il, ir, output f, c8);
`endif
endinterface

// File: rtl/alu_4bit.sv
// 4-bit registered ALU slice: ripple-carry arithmetic, bitwise logic, 1-bit shifts.
// Optional registered zero flag z under ALU_ZERO_FLAG_EN.
module alu_4bit (
  input  logic      clk,
  input  logic      rst,
  alu_4bit_if.slave bus
);
  typedef struct packed {
    logic       c8;
    logic [3:0] f;
  } alu_res_t;

  alu_res_t   arith, logic_r, shl, shr, nxt;
  logic [3:0] y, sum;
  logic [4:0] cy;

  always_comb begin
    case ({bus.s1, bus.s0})
      2'b00:   y = 4'h0;
      2'b01:   y = bus.b;
      2'b10:   y = ~bus.b;
      default: y = 4'hF;
    endcase
  end

  // Explicit ripple chain so c8 falls out as the final carry, which doubles
  // as the no-borrow indication for the subtract forms.
  assign cy[0] = bus.c0;
  for (genvar i = 0; i < 4; i++) begin : g_rca
    assign sum[i]  = bus.a[i] ^ y[i] ^ cy[i];
    assign cy[i+1] = (bus.a[i] & y[i]) | (cy[i] & (bus.a[i] ^ y[i]));
  end

  always_comb begin
    arith     = '{c8: cy[4], f: sum};
    logic_r.c8 = 1'b0;
    case ({bus.s1, bus.s0})
      2'b00:   logic_r.f = bus.a | bus.b;
      2'b01:   logic_r.f = bus.a ^ bus.b;
      2'b10:   logic_r.f = bus.a & bus.b;
      default: logic_r.f = ~bus.a;
    endcase
    shl = '{c8: bus.a[3], f: {bus.a[2:0], bus.ir}};
    shr = '{c8: bus.a[0], f: {bus.il, bus.a[3:1]}};
    case ({bus.s3, bus.s2})
      2'b00:   nxt = arith;
      2'b01:   nxt = logic_r;
      2'b10:   nxt = shl;
      default: nxt = shr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.f  <= 4'h0;
      bus.c8 <= 1'b0;
    end else begin
      bus.f  <= nxt.f;
      bus.c8 <= nxt.c8;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) bus.z <= 1'b1;
    else     bus.z <= (nxt.f == 4'h0);
  end
`endif
endmodule

// File: tb/tb_alu_4bit.sv
// Directed-vector bench for alu_4bit; expected {c8,f} values are hand-computed.
module tb_alu_4bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_4bit_if bus ();
  alu_4bit u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                       input logic c0, input logic il, input logic ir);
    bus.a  = a;
    bus.b  = b;
    {bus.s3, bus.s2, bus.s1, bus.s0} = s;
    bus.c0 = c0;
    bus.il = il;
    bus.ir = ir;
  endtask

  // Apply one vector, clock it, then compare the registered result.
  task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] s, input logic c0, input logic il, input logic ir,
                     input logic [4:0] exp);
    drive(a, b, s, c0, il, ir);
    @(posedge clk);
    #1;
    chk(tag, {3'b0, bus.c8, bus.f}, {3'b0, exp});
`ifdef ALU_ZERO_FLAG_EN
    chk({tag, ".z"}, {7'b0, bus.z}, {7'b0, (exp[3:0] == 4'h0)});
`endif
  endtask

  logic [4:0] sweep_exp [8] = '{5'h09, 5'h0A, 5'h13, 5'h14, 5'h0E, 5'h0F, 5'h18, 5'h19};
  logic [3:0] logic_exp [4] = '{4'h7, 4'h3, 4'h4, 4'hA};

  typedef struct {
    logic [3:0] a, b, s;
    logic       c0, il, ir;
    logic [4:0] exp;
  } bb_vec_t;

  bb_vec_t bb [7] = '{
    '{4'h3, 4'h5, 4'b0001, 1'b0, 1'b0, 1'b0, 5'h08},
    '{4'hC, 4'h5, 4'b0110, 1'b1, 1'b0, 1'b0, 5'h04},
    '{4'hE, 4'h0, 4'b1000, 1'b1, 1'b0, 1'b0, 5'h1C},
    '{4'h6, 4'h0, 4'b1100, 1'b0, 1'b1, 1'b0, 5'h0B},
    '{4'h2, 4'h3, 4'b0010, 1'b1, 1'b0, 1'b0, 5'h0F},
    '{4'hA, 4'h0, 4'b0111, 1'b0, 1'b0, 1'b0, 5'h05},
    '{4'h8, 4'h8, 4'b0001, 1'b0, 1'b0, 1'b0, 5'h10}
  };

  initial begin
    // Reset held for two edges with live operands.
    rst = 1'b1;
    drive(4'h7, 4'h6, 4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.f",  {4'b0, bus.f},  8'h00);
    chk("rst.c8", {7'b0, bus.c8}, 8'h00);
`ifdef ALU_ZERO_FLAG_EN
    chk("rst.z",  {7'b0, bus.z},  8'h01);
`endif
    rst = 1'b0;
    vec("rst.rel", 4'h7, 4'h6, 4'b0001, 1'b0, 1'b0, 1'b0, 5'h0D);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] code;
      code = 3'(i);
      vec($sformatf("arith.%0d", i), 4'h9, 4'hA, {2'b00, code[2:1]}, code[0], 1'b0, 1'b0,
          sweep_exp[i]);
    end

    vec("bnd.inc_wrap", 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 5'h10);
    vec("bnd.dec_wrap", 4'h0, 4'h0, 4'b0011, 1'b0, 1'b0, 1'b0, 5'h0F);
    vec("bnd.sub",      4'h7, 4'h6, 4'b0010, 1'b1, 1'b0, 1'b0, 5'h11);

    for (int i = 0; i < 4; i++) begin
      logic [1:0] fn;
      fn = 2'(i);
      vec($sformatf("logic.%0d", i), 4'h5, 4'h6, {2'b01, fn}, 1'b1, 1'b0, 1'b0,
          {1'b0, logic_exp[i]});
    end

    vec("shl",      4'h9, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b1, 5'h13);
    vec("shr",      4'h9, 4'h0, 4'b1100, 1'b0, 1'b1, 1'b0, 5'h1C);
    vec("shr.zero", 4'h1, 4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 5'h10);

    for (int i = 0; i < 7; i++)
      vec($sformatf("b2b.%0d", i), bb[i].a, bb[i].b, bb[i].s, bb[i].c0, bb[i].il, bb[i].ir,
          bb[i].exp);

    // Mid-stream reset discards the in-flight result.
    drive(4'hF, 4'h0, 4'b0111, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.mid", {3'b0, bus.c8, bus.f}, 8'h00);
    rst = 1'b0;
    vec("rst.mid.rel", 4'h4, 4'h3, 4'b0001, 1'b1, 1'b0, 1'b0, 5'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
